mult_seq_unit: RTL and testbench

- Sequential radix-2 shift-add 32x32 multiplier core for the MIPS MULT/MULTU path. It produces the 64-bit HI/LO product.
- Sits directly upstream of the 5-bit 8:1 select mux in the multiplier. It drives that mux's 3-bit select (phase code) and the 5-bit iteration index that the mux steers onward.
- Start/Busy/Done handshake toward the CPU control unit.

---
 rtl/mult_seq_unit.sv | 162 ++++++++++++++++
 tb/tb_mult_seq_unit.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_seq_unit.sv
// Sequential radix-2 shift-add WIDTHxWIDTH multiplier (MULT/MULTU) with Start/Busy/Done handshake.
// Optional early termination on an exhausted multiplier: define MULT_SEQ_EARLY_TERM_EN.
module mult_seq_unit #(
    parameter int WIDTH = 32
) (
    input  logic                       Clk,
    input  logic                       ResetN,
    input  logic                       Start,
    input  logic                       Signed,
    input  logic [WIDTH-1:0]           A,
    input  logic [WIDTH-1:0]           B,
    output logic                       Busy,
    output logic                       Done,
    output logic [WIDTH-1:0]           Hi,
    output logic [WIDTH-1:0]           Lo,
    output logic [2:0]                 Sel,
    output logic [$clog2(WIDTH)-1:0]   Count
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_ITER  = 3'd2,
        S_FIXUP = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t                 r_state;
    logic [WIDTH-1:0]       r_a;
    logic [WIDTH-1:0]       r_b;
    logic                   r_signed;
    logic                   r_neg;
    logic [WIDTH-1:0]       r_mcand;
    logic [WIDTH-1:0]       r_mplier;
    logic [WIDTH-1:0]       r_acc;

    logic [WIDTH-1:0]       w_addend;
    logic [WIDTH:0]         w_sum;
    logic [2*WIDTH-1:0]     w_prod;
    logic                   w_last;

    // Magnitude of a possibly signed operand; the most negative value maps onto itself,
    // which is its correct unsigned magnitude.
    function automatic logic [WIDTH-1:0] f_mag(input logic [WIDTH-1:0] v, input logic is_signed);
        logic signed [WIDTH-1:0] s;
        s = v;
        if (is_signed && s[WIDTH-1])
            return WIDTH'(-s);
        return v;
    endfunction

    function automatic logic [2*WIDTH-1:0] f_fix(input logic [2*WIDTH-1:0] p, input logic neg);
        logic [2*WIDTH-1:0] one;
        one = '0;
        one[0] = 1'b1;
        if (neg)
            return (~p) + one;
        return p;
    endfunction

    assign w_addend = r_mplier[0] ? r_mcand : '0;
    assign w_sum    = {1'b0, r_acc} + {1'b0, w_addend};
    assign w_prod   = {r_acc, r_mplier};
    assign w_last   = (Count == CNT_LAST);

`ifdef MULT_SEQ_EARLY_TERM_EN
    localparam logic [WIDTH-1:0] ALL_ONES = '1;
    logic [WIDTH-1:0]       w_mask;
    logic                   w_rem_zero;
    logic [CW:0]            w_shamt;
    logic [2*WIDTH-1:0]     w_early;

    // The low (WIDTH - Count) multiplier bits are the ones not yet consumed.
    assign w_mask     = ALL_ONES >> Count;
    assign w_rem_zero = ((r_mplier & w_mask) == '0);
    assign w_shamt    = (CW+1)'(WIDTH) - {1'b0, Count};
    assign w_early    = w_prod >> w_shamt;
`endif

    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            r_state  <= S_IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_signed <= 1'b0;
            r_neg    <= 1'b0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            Busy     <= 1'b0;
            Done     <= 1'b0;
            Hi       <= '0;
            Lo       <= '0;
            Sel      <= 3'd0;
            Count    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (Start) begin
                        r_a      <= A;
                        r_b      <= B;
                        r_signed <= Signed;
                        r_neg    <= Signed & (A[WIDTH-1] ^ B[WIDTH-1]);
                        Busy     <= 1'b1;
                        r_state  <= S_LOAD;
                        Sel      <= 3'd1;
                    end
                end
                S_LOAD: begin
                    r_mcand  <= f_mag(r_a, r_signed);
                    r_mplier <= f_mag(r_b, r_signed);
                    r_acc    <= '0;
                    Count    <= '0;
                    r_state  <= S_ITER;
                    Sel      <= 3'd2;
                end
                S_ITER: begin
`ifdef MULT_SEQ_EARLY_TERM_EN
                    if (w_rem_zero) begin
                        {r_acc, r_mplier} <= w_early;
                        r_state           <= S_FIXUP;
                        Sel               <= 3'd3;
                    end else
`endif
                    begin
                        // Conditional add into the upper half, then shift {carry, acc, mplier} right.
                        r_acc    <= w_sum[WIDTH:1];
                        r_mplier <= {w_sum[0], r_mplier[WIDTH-1:1]};
                        if (w_last) begin
                            r_state <= S_FIXUP;
                            Sel     <= 3'd3;
                        end else begin
                            Count <= Count + CW'(1);
                        end
                    end
                end
                S_FIXUP: begin
                    {Hi, Lo} <= f_fix(w_prod, r_neg);
                    Done     <= 1'b1;
                    r_state  <= S_DONE;
                    Sel      <= 3'd4;
                end
                S_DONE: begin
                    Done    <= 1'b0;
                    Busy    <= 1'b0;
                    r_state <= S_IDLE;
                    Sel     <= 3'd0;
                end
                default: begin
                    Done    <= 1'b0;
                    Busy    <= 1'b0;
                    r_state <= S_IDLE;
                    Sel     <= 3'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_seq_unit.sv
// Directed self-checking bench for mult_seq_unit; expectations follow MULT_SEQ_EARLY_TERM_EN when defined.
module tb_mult_seq_unit;

    logic        Clk = 1'b0;
    logic        ResetN;
    logic        Start;
    logic        Signed;
    logic [31:0] A;
    logic [31:0] B;
    logic        Busy;
    logic        Done;
    logic [31:0] Hi;
    logic [31:0] Lo;
    logic [2:0]  Sel;
    logic [4:0]  Count;

    int checks = 0;
    int failures = 0;

    int          r_lat;
    logic [31:0] r_hi, r_lo, hi_mid, lo_mid;
    logic [4:0]  cnt_done;
    logic [2:0]  sel_after;
    logic        busy_after, done_after, busy0;
    logic [2:0]  sel_log [0:127];

    mult_seq_unit #(.WIDTH(32)) dut (
        .Clk(Clk), .ResetN(ResetN), .Start(Start), .Signed(Signed),
        .A(A), .B(B), .Busy(Busy), .Done(Done), .Hi(Hi), .Lo(Lo),
        .Sel(Sel), .Count(Count)
    );

    always #5 Clk = ~Clk;

    initial begin
        #500000;
        $display("FAIL watchdog time limit expired");
        $fatal(1);
    end

    // Runs one operation; k counts cycles after the Start cycle (k=0).
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s);
        @(negedge Clk);
        Start = 1'b1; A = a; B = b; Signed = s;
        sel_log[0] = Sel;
        busy0 = Busy;
        @(negedge Clk);
        Start = 1'b0; A = ~a; B = b ^ 32'h5A5A_5A5A; Signed = ~s;
        r_lat = -1;
        for (int k = 1; k < 100; k++) begin
            sel_log[k] = Sel;
            if (k == 2) begin hi_mid = Hi; lo_mid = Lo; end
            if (Done) begin
                r_lat = k; r_hi = Hi; r_lo = Lo; cnt_done = Count;
                break;
            end
            @(negedge Clk);
        end
        @(negedge Clk);
        sel_after = Sel; busy_after = Busy; done_after = Done;
    endtask

    task automatic test_reset();
        ResetN = 1'b0; Start = 1'b0; Signed = 1'b0; A = '0; B = '0;
        repeat (2) @(negedge Clk);
        checks++;
        if ({Busy, Done, Sel, Count} !== 10'd0) begin
            failures++;
            $display("FAIL reset_ctrl got busy=%b done=%b sel=%0d count=%0d exp all 0", Busy, Done, Sel, Count);
        end
        checks++;
        if ({Hi, Lo} !== 64'd0) begin
            failures++;
            $display("FAIL reset_hilo got %h_%h exp 0", Hi, Lo);
        end
        ResetN = 1'b1;
        repeat (2) @(negedge Clk);
        checks++;
        if ({Busy, Done, Sel} !== 5'd0) begin
            failures++;
            $display("FAIL idle_after_reset got busy=%b done=%b sel=%0d exp 0", Busy, Done, Sel);
        end
    endtask

    task automatic test_multu();
        int bad;
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        checks++;
        if (r_lat !== 35) begin failures++; $display("FAIL multu_latency got %0d exp 35", r_lat); end
        checks++;
        if ({r_hi, r_lo} !== 64'hFFFF_FFFE_0000_0001) begin
            failures++; $display("FAIL multu_product got %h_%h exp fffffffe_00000001", r_hi, r_lo);
        end
        bad = 0;
        for (int k = 0; k <= 35; k++) begin
            if (k == 0 && sel_log[k] !== 3'd0) bad++;
            if (k == 1 && sel_log[k] !== 3'd1) bad++;
            if (k >= 2 && k <= 33 && sel_log[k] !== 3'd2) bad++;
            if (k == 34 && sel_log[k] !== 3'd3) bad++;
            if (k == 35 && sel_log[k] !== 3'd4) bad++;
        end
        checks++;
        if (bad !== 0 || sel_after !== 3'd0) begin
            failures++; $display("FAIL multu_sel_seq got %0d wrong codes, after=%0d exp 0 wrong, after=0", bad, sel_after);
        end
        checks++;
        if (cnt_done !== 5'd31) begin failures++; $display("FAIL multu_count_done got %0d exp 31", cnt_done); end
        checks++;
        if (busy0 !== 1'b0 || busy_after !== 1'b0 || done_after !== 1'b0) begin
            failures++;
            $display("FAIL multu_handshake got busy0=%b busy_after=%b done_after=%b exp 0 0 0", busy0, busy_after, done_after);
        end
        repeat (3) @(negedge Clk);
        checks++;
        if ({Hi, Lo} !== 64'hFFFF_FFFE_0000_0001) begin
            failures++; $display("FAIL multu_hold got %h_%h exp fffffffe_00000001", Hi, Lo);
        end
    endtask

    task automatic test_mult_mixed();
        int exp_lat;
`ifdef MULT_SEQ_EARLY_TERM_EN
        exp_lat = 7;
`else
        exp_lat = 35;
`endif
        run_op(32'hFFFF_FFFD, 32'h0000_0007, 1'b1);
        checks++;
        if ({r_hi, r_lo} !== 64'hFFFF_FFFF_FFFF_FFEB) begin
            failures++; $display("FAIL mixed_product got %h_%h exp ffffffff_ffffffeb", r_hi, r_lo);
        end
        checks++;
        if (r_lat !== exp_lat) begin failures++; $display("FAIL mixed_latency got %0d exp %0d", r_lat, exp_lat); end
    endtask

    task automatic test_mult_corner();
        int exp_lat;
        run_op(32'h8000_0000, 32'h8000_0000, 1'b1);
        checks++;
        if ({r_hi, r_lo} !== 64'h4000_0000_0000_0000) begin
            failures++; $display("FAIL corner_minsq got %h_%h exp 40000000_00000000", r_hi, r_lo);
        end
        checks++;
        if (r_lat !== 35) begin failures++; $display("FAIL corner_minsq_latency got %0d exp 35", r_lat); end
`ifdef MULT_SEQ_EARLY_TERM_EN
        exp_lat = 5;
`else
        exp_lat = 35;
`endif
        run_op(32'h8000_0000, 32'h0000_0001, 1'b1);
        checks++;
        if ({hi_mid, lo_mid} !== 64'h4000_0000_0000_0000) begin
            failures++; $display("FAIL corner_hold_inflight got %h_%h exp 40000000_00000000", hi_mid, lo_mid);
        end
        checks++;
        if ({r_hi, r_lo} !== 64'hFFFF_FFFF_8000_0000 || r_lat !== exp_lat) begin
            failures++;
            $display("FAIL corner_min_x1 got %h_%h lat=%0d exp ffffffff_80000000 lat=%0d", r_hi, r_lo, r_lat, exp_lat);
        end
    endtask

    task automatic test_reset_mid_iter();
        logic found, done_seen;
        int exp_lat;
        @(negedge Clk);
        Start = 1'b1; A = 32'h1234_5678; B = 32'h8765_4321; Signed = 1'b0;
        @(negedge Clk);
        Start = 1'b0;
        found = 1'b0;
        for (int t = 0; t < 60; t++) begin
            if (Sel == 3'd2 && Count == 5'd10) begin found = 1'b1; break; end
            @(negedge Clk);
        end
        checks++;
        if (found !== 1'b1) begin failures++; $display("FAIL midreset_reach_count10 got %b exp 1", found); end
        ResetN = 1'b0;
        #1;
        checks++;
        if ({Busy, Done, Sel, Count} !== 10'd0 || {Hi, Lo} !== 64'd0) begin
            failures++;
            $display("FAIL midreset_outputs got busy=%b done=%b sel=%0d count=%0d hilo=%h_%h exp all 0",
                     Busy, Done, Sel, Count, Hi, Lo);
        end
        done_seen = 1'b0;
        repeat (3) begin
            @(posedge Clk); #1;
            if (Done) done_seen = 1'b1;
        end
        checks++;
        if (done_seen !== 1'b0) begin failures++; $display("FAIL midreset_no_done got %b exp 0", done_seen); end
        @(negedge Clk);
        ResetN = 1'b1;
`ifdef MULT_SEQ_EARLY_TERM_EN
        exp_lat = 21;
`else
        exp_lat = 35;
`endif
        run_op(32'h0001_0000, 32'h0001_0000, 1'b0);
        checks++;
        if ({r_hi, r_lo} !== 64'h0000_0001_0000_0000 || r_lat !== exp_lat) begin
            failures++;
            $display("FAIL midreset_clean_op got %h_%h lat=%0d exp 00000001_00000000 lat=%0d", r_hi, r_lo, r_lat, exp_lat);
        end
    endtask

    task automatic test_back_to_back();
        int npulse, first, second, exp_n, exp_first, exp_second, chg_on, chg_off;
        logic [31:0] hi50, lo50;
`ifdef MULT_SEQ_EARLY_TERM_EN
        exp_n = 8; exp_first = 6; exp_second = 13; chg_on = 2; chg_off = 5;
`else
        exp_n = 2; exp_first = 35; exp_second = 71; chg_on = 5; chg_off = 30;
`endif
        npulse = 0; first = -1; second = -1; hi50 = '0; lo50 = '0;
        @(negedge Clk);
        Start = 1'b1; A = 32'd2; B = 32'd3; Signed = 1'b0;
        for (int t = 1; t <= 80; t++) begin
            @(negedge Clk);
            if (Done) begin
                npulse++;
                if (first < 0) first = t;
                else if (second < 0) second = t;
            end
            if (t == chg_on) begin A = 32'hDEAD_0000; B = 32'h0000_BEEF; Signed = 1'b1; end
            if (t == chg_off) begin A = 32'd2; B = 32'd3; Signed = 1'b0; end
            if (t == 50) begin Start = 1'b0; hi50 = Hi; lo50 = Lo; end
        end
        checks++;
        if (npulse !== exp_n) begin failures++; $display("FAIL b2b_pulse_count got %0d exp %0d", npulse, exp_n); end
        checks++;
        if (first !== exp_first || second !== exp_second) begin
            failures++; $display("FAIL b2b_done_cycles got %0d,%0d exp %0d,%0d", first, second, exp_first, exp_second);
        end
        checks++;
        if ({hi50, lo50} !== 64'd6 || {Hi, Lo} !== 64'd6) begin
            failures++; $display("FAIL b2b_product got %h_%h end=%h_%h exp 0_6", hi50, lo50, Hi, Lo);
        end
    endtask

    task automatic test_early_term();
        int lat0, lat1;
        logic [4:0] cnt1;
`ifdef MULT_SEQ_EARLY_TERM_EN
        lat0 = 4; lat1 = 5; cnt1 = 5'd1;
`else
        lat0 = 35; lat1 = 35; cnt1 = 5'd31;
`endif
        run_op(32'd5, 32'd0, 1'b0);
        checks++;
        if ({r_hi, r_lo} !== 64'd0 || r_lat !== lat0) begin
            failures++; $display("FAIL early_b0 got %h_%h lat=%0d exp 0_0 lat=%0d", r_hi, r_lo, r_lat, lat0);
        end
        run_op(32'd5, 32'd1, 1'b0);
        checks++;
        if ({r_hi, r_lo} !== 64'd5 || r_lat !== lat1) begin
            failures++; $display("FAIL early_b1 got %h_%h lat=%0d exp 0_5 lat=%0d", r_hi, r_lo, r_lat, lat1);
        end
        checks++;
        if (cnt_done !== cnt1) begin failures++; $display("FAIL early_b1_count got %0d exp %0d", cnt_done, cnt1); end
    endtask

    initial begin
        test_reset();
        test_multu();
        test_mult_mixed();
        test_mult_corner();
        test_reset_mid_iter();
        test_back_to_back();
        test_early_term();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
